// File: rtl/halt_dump_ctrl.sv
// halt_dump_ctrl
//   Processor-side end of the simulation completion handshake. On a sampled
//   `complete` it freezes fetch, waits for the pipeline to drain, streams the
//   architectural register file out over a valid/ready dump port and then
//   raises a sticky `done`.
//
// Ports
//   clk, reset      single clock, synchronous active-high reset
//   complete        halt request from the bench (level, only looked at in RUN)
//   pipe_empty      no instruction in flight past fetch
//   retire          one-cycle pulse per retired instruction
//   fetch_stall     hold fetch PC / insert bubbles
//   rf_raddr        spare register-file read port address
//   rf_rdata        asynchronous read data for rf_raddr
//   dump_valid/dump_ready/dump_addr/dump_data   register dump stream
//   retired_count   retired instructions, frozen once the dump starts
//   done            dump finished, sticky until reset
//
// state | meaning
// RUN   | normal execution, counting retires, watching complete
// DRAIN | fetch frozen, waiting DRAIN_MIN cycles and for pipe_empty
// DUMP  | streaming registers 0..NUM_REGS-1 out of the dump port
// DONE  | dump finished, everything frozen until reset

module halt_dump_ctrl #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int DRAIN_MIN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              complete,
  input  logic              pipe_empty,
  input  logic              retire,
  output logic              fetch_stall,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic [31:0]       retired_count,
  output logic              done
);

  localparam int CNT_W = (DRAIN_MIN > 1) ? $clog2(DRAIN_MIN) : 1;
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_MIN - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DUMP  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    drain_cnt_q, drain_cnt_d;
  logic                fetch_stall_q, fetch_stall_d;
  logic [ADDR_W-1:0]   rf_raddr_q, rf_raddr_d;
  logic                dump_valid_q, dump_valid_d;
  logic [ADDR_W-1:0]   dump_addr_q, dump_addr_d;
  logic [DATA_W-1:0]   dump_data_q, dump_data_d;
  logic [31:0]         retired_count_q, retired_count_d;
  logic                done_q, done_d;
  logic                load_beat;

  always_comb begin
    state_d         = state_q;
    drain_cnt_d     = drain_cnt_q;
    rf_raddr_d      = rf_raddr_q;
    dump_valid_d    = dump_valid_q;
    dump_addr_d     = dump_addr_q;
    dump_data_d     = dump_data_q;
    retired_count_d = retired_count_q;
    load_beat       = 1'b0;

    unique case (state_q)
      S_RUN: begin
        drain_cnt_d = '0;
        if (complete) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_cnt_q >= DRAIN_LAST && pipe_empty) begin
          state_d = S_DUMP;
        end else if (drain_cnt_q < DRAIN_LAST) begin
          drain_cnt_d = drain_cnt_q + CNT_W'(1);
        end
      end
      S_DUMP: begin
        // First DUMP cycle has no beat yet: it only loads beat 0, so the
        // registered data is settled before dump_valid is ever seen.
        if (!dump_valid_q) begin
          load_beat = 1'b1;
        end else if (dump_ready) begin
          if (dump_addr_q == LAST_IDX) begin
            state_d      = S_DONE;
            dump_valid_d = 1'b0;
          end else begin
            load_beat = 1'b1;
          end
        end
      end
      S_DONE: begin
      end
      default: state_d = S_RUN;
    endcase

    // rf_raddr runs one index ahead of the presented beat so that a
    // transfer can load the next beat in the same cycle.
    if (load_beat) begin
      dump_valid_d = 1'b1;
      dump_addr_d  = rf_raddr_q;
      dump_data_d  = rf_rdata;
      if (rf_raddr_q != LAST_IDX) rf_raddr_d = rf_raddr_q + ADDR_W'(1);
    end

    if (retire && (state_q == S_RUN || state_q == S_DRAIN)) begin
      retired_count_d = retired_count_q + 32'd1;
    end

    fetch_stall_d = (state_d != S_RUN);
    done_d        = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_RUN;
      drain_cnt_q     <= '0;
      fetch_stall_q   <= 1'b0;
      rf_raddr_q      <= '0;
      dump_valid_q    <= 1'b0;
      dump_addr_q     <= '0;
      dump_data_q     <= '0;
      retired_count_q <= '0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      drain_cnt_q     <= drain_cnt_d;
      fetch_stall_q   <= fetch_stall_d;
      rf_raddr_q      <= rf_raddr_d;
      dump_valid_q    <= dump_valid_d;
      dump_addr_q     <= dump_addr_d;
      dump_data_q     <= dump_data_d;
      retired_count_q <= retired_count_d;
      done_q          <= done_d;
    end
  end

  assign fetch_stall   = fetch_stall_q;
  assign rf_raddr      = rf_raddr_q;
  assign dump_valid    = dump_valid_q;
  assign dump_addr     = dump_addr_q;
  assign dump_data     = dump_data_q;
  assign retired_count = retired_count_q;
  assign done          = done_q;

endmodule
